// File: rtl/led_uart_pkg.sv
// Shared types and constants for the LED snapshot UART transmitter.
package led_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/led_snap_fifo.sv
// Synchronous snapshot queue; a full queue still accepts a push that
// coincides with a pop, otherwise the push is dropped and flagged.
module led_snap_fifo
    import led_uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = DATA_BITS
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [W-1:0]           i_data,
    output logic [W-1:0]           o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign w_wr    = i_push && (!w_full || w_pop);
    assign o_drop  = i_push && !w_wr;
    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/led_uart_tx.sv
// Queues every LED change and sends each snapshot as an 8N1 UART frame.
module led_uart_tx
    import led_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        original_clk,
    input  logic                        rst,
    input  logic [7:0]                  leds,
    output logic                        tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [15:0]          r_cnt;
    logic [15:0]          w_cnt_next;
    logic [2:0]           r_idx;
    logic [2:0]           w_idx_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [DATA_BITS-1:0] r_prev;
    logic [DATA_BITS-1:0] w_head;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 r_ovf;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_last;

    assign w_push = !rst && (leds != r_prev);
    assign w_last = (r_cnt == LAST_CNT);

    led_snap_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_BITS)
    ) u_fifo (
        .i_clk   (original_clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (leds),
        .o_head  (w_head),
        .o_count (fifo_count),
        .o_drop  (w_drop)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 16'd1;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (fifo_count != '0) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_last) begin
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_last) begin
                    w_cnt_next = '0;
                    w_idx_next = r_idx + 3'd1;
                    if (r_idx == LAST_DATA) begin
                        w_idx_next   = '0;
                        w_state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (w_last) begin
                    w_cnt_next = '0;
                    w_idx_next = r_idx + 3'd1;
                    if (r_idx == LAST_STOP) begin
                        w_idx_next   = '0;
                        w_state_next = IDLE;
                    end
                end
            end
        endcase
        // tx is registered from the next state so the line never glitches
        unique case (w_state_next)
            IDLE:  w_tx_next = 1'b1;
            START: w_tx_next = 1'b0;
            DATA:  w_tx_next = w_shift_next[w_idx_next];
            STOP:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge original_clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_prev  <= '0;
            r_tx    <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_prev  <= leds;
            r_tx    <= w_tx_next;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign tx       = r_tx;
    assign busy     = (r_state != IDLE);
    assign overflow = r_ovf;

endmodule

// File: tb/tb_led_uart_tx.sv
// Randomised bench for led_uart_tx against a frame-level reference model.
module tb_led_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FLEN  = 10 * CPB;

    logic                    clk;
    logic                    rst;
    logic [7:0]              leds;
    logic                    tx;
    logic                    busy;
    logic                    overflow;
    logic [$clog2(DEPTH):0]  fifo_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_q[$];
    logic [7:0] m_prev;
    logic [7:0] m_byte;
    int         m_rem;
    logic       m_ovf;

    led_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .original_clk (clk),
        .rst          (rst),
        .leds         (leds),
        .tx           (tx),
        .busy         (busy),
        .overflow     (overflow),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Expected line level from position inside the current frame
    function automatic logic exp_tx();
        int k;
        if (m_rem == 0) return 1'b1;
        k = (FLEN - m_rem) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    task automatic step(input logic [7:0] v, input logic r);
        bit idle;
        bit pop;
        leds = v;
        rst  = r;
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_rem  = 0;
            m_prev = 8'h00;
            m_ovf  = 1'b0;
        end else begin
            idle = (m_rem == 0);
            if (!idle) m_rem--;
            pop = idle && (m_q.size() > 0);
            if (pop) begin
                m_byte = m_q.pop_front();
                m_rem  = FLEN;
            end
            if (v != m_prev) begin
                if (m_q.size() < DEPTH || pop) m_q.push_back(v);
                else m_ovf = 1'b1;
            end
            m_prev = v;
        end
        #1;
        check("tx", 32'(tx), 32'(exp_tx()));
        check("busy", 32'(busy), 32'(m_rem != 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    endtask

    initial begin
        logic [7:0] v;
        m_prev = 8'h00;
        m_byte = 8'h00;
        m_rem  = 0;
        m_ovf  = 1'b0;
        leds   = 8'h00;
        rst    = 1'b1;

        repeat (3) step(8'h00, 1'b1);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_cnt", 32'(fifo_count), 32'd0);

        step(8'hA5, 1'b0);
        check("a5_wait_tx", 32'(tx), 32'd1);
        step(8'hA5, 1'b0);
        check("a5_start", 32'(tx), 32'd0);
        repeat (50) step(8'hA5, 1'b0);

        step(8'h01, 1'b0);
        step(8'h02, 1'b0);
        step(8'h03, 1'b0);
        repeat (140) step(8'h03, 1'b0);
        check("b2b_ovf", 32'(overflow), 32'd0);

        foreach (m_q[i]) m_q[i] = m_q[i];
        step(8'h11, 1'b0);
        step(8'h22, 1'b0);
        step(8'h33, 1'b0);
        step(8'h44, 1'b0);
        step(8'h55, 1'b0);
        step(8'h66, 1'b0);
        check("six_ovf", 32'(overflow), 32'd1);
        check("six_cnt", 32'(fifo_count), 32'(DEPTH));
        repeat (240) step(8'h66, 1'b0);

        repeat (2) step(8'h00, 1'b1);
        step(8'h10, 1'b0);
        step(8'h20, 1'b0);
        step(8'h30, 1'b0);
        step(8'h40, 1'b0);
        step(8'h50, 1'b0);
        for (int i = 0; i < 100 && m_rem != 0; i++) step(8'h50, 1'b0);
        check("idle_full_cnt", 32'(fifo_count), 32'(DEPTH));
        step(8'h60, 1'b0);
        check("pop_push_cnt", 32'(fifo_count), 32'(DEPTH));
        check("pop_push_ovf", 32'(overflow), 32'd0);
        repeat (220) step(8'h60, 1'b0);

        repeat (2) step(8'h00, 1'b1);
        step(8'h5A, 1'b0);
        repeat (15) step(8'h5A, 1'b0);
        check("mid_busy", 32'(busy), 32'd1);
        step(8'h00, 1'b1);
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cnt", 32'(fifo_count), 32'd0);
        repeat (100) step(8'h00, 1'b0);

        v = 8'h00;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) < 3) v = 8'($urandom);
            step(v, $urandom_range(0, 199) == 0);
        end

        repeat (300) step(v, 1'b0);
        for (int i = 0; i < 200; i++) begin
            step(v, 1'b0);
            check("quiet_tx", 32'(tx), 32'd1);
        end
        check("quiet_cnt", 32'(fifo_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
